coord_ram_reader: RTL
=====================

// Module: coord_ram_reader
// PURPOSE
//  Pipelined display-coordinate to banked-RAM read engine for the spectrogram display path.
//  Maps each valid pixel coordinate (x,y) to a one-hot bank select and a bank-local address,
//  then issues the read. Tracks the bank of every read in flight across the RAM latency.
//  Returns the read pixel word, aligned with pixel_valid. Sits between the video timing
//  generator and the shared memory banks.
// PARAMETERS
//  NO_BANKS        8   number of RAM banks (one-hot select width)
//  COORDW          10  width of x and y
//  RAM_ADDR_WIDTH  12  bank-local address width; must be >= ROW_LOG2+LINE_LOG2
//  LINE_LOG2       9   log2 of words per stored line (x field width used in address)
//  ROW_LOG2        3   log2 of stored lines per bank
//  Y_DECIM_LOG2    3   log2 of display lines sharing one stored line (y LSBs dropped)
//  DATAW           8   RAM word / pixel width
//  RAM_LAT         1   cycles from rd_en to valid bank data (>=1)
//  BG_PIXEL        0   pixel value returned for out-of-range coordinates
// PORTS
//  clk             in   1                clock
//  rst             in   1                reset, asynchronous, active-high
//  flush           in   1                sync: kill all in-flight reads (frame start)
//  coord_valid     in   1                x,y valid this cycle
//  x               in   COORDW           display column
//  y               in   COORDW           display row
//  rd_en           out  1                read strobe to banks
//  rd_bank_select  out  NO_BANKS         one-hot bank select, qualified by rd_en
//  rd_address      out  RAM_ADDR_WIDTH   bank-local read address
//  bank_rdata      in   NO_BANKS*DATAW   concatenated bank read data, bank0 at LSBs
//  pixel_valid     out  1                pixel_data valid
//  pixel_data      out  DATAW            returned pixel
//  oor_count       out  16               out-of-range count (only with COORD_RAM_BOUNDS_EN)
// BEHAVIOUR
//  Reset: rd_en=0, rd_bank_select=0, rd_address=0, pixel_valid=0, pixel_data=0, oor_count=0.
//   All tag/valid pipeline stages are cleared.
//  Field split:
//   bank = y[COORDW-1 : ROW_LOG2+Y_DECIM_LOG2]
//   row  = y[ROW_LOG2+Y_DECIM_LOG2-1 : Y_DECIM_LOG2]
//   rd_address = {row, x[LINE_LOG2-1:0]}, zero-extended to RAM_ADDR_WIDTH (no adder).
//  Stage 1 (cycle N+1 after coord_valid at N): rd_en, rd_bank_select and rd_address registered.
//   rd_bank_select = 1<<bank. When rd_en=0, select and address hold 0.
//  Tag pipe: {valid, bank index, oor} delayed RAM_LAT cycles behind rd_en.
//  Output register: at cycle N+1+RAM_LAT+1, pixel_valid=1 and pixel_data=bank_rdata slice[tag bank].
//   If the tag's oor bit is set, pixel_data=BG_PIXEL instead.
//  Throughput: one coordinate per cycle, no backpressure. Back-to-back reads to different banks
//   return in issue order.
//  flush: clears stage 1 and the tag pipe on the same edge. pixel_valid=0 on the next cycle.
//   A coord_valid in the flush cycle is dropped.
//  Reset mid-operation: all in-flight reads are discarded. No pixel_valid until new coordinates arrive.
//  pixel_valid with coord_valid low: 0. No spurious outputs.
// CONFIGURATION
//  COORD_RAM_BOUNDS_EN defined:
//   - Coordinate is out of range if bank>=NO_BANKS or x>=2**LINE_LOG2.
//   - Out-of-range coordinate: rd_en stays 0 and the bank is not strobed. Still occupies a
//     pipeline slot, and pixel_data=BG_PIXEL with pixel_valid=1 at the normal latency.
//   - oor_count increments per out-of-range coordinate, saturates at 16'hFFFF, cleared by reset only.
//  Not defined:
//   - No range check. bank truncated to log2(NO_BANKS) bits (wraps). x upper bits dropped.
//   - oor_count tied 0. Every coordinate issues a read.
// STRUCTURE
//  Package coord_ram_pkg holds:
//   - clog2 function
//   - derived localparams BANKW=COORDW-ROW_LOG2-Y_DECIM_LOG2 and BANK_IDXW=clog2(NO_BANKS)
//   - tag struct/field widths {valid, oor, bank_idx}
//  Sub-module coord_ram_tag_pipe holds the RAM_LAT-deep tag shift register, with flush and async reset.
// TESTING
//  1. Defaults; x=5,y=0 valid one cycle -> cycle+1: rd_en=1, sel=8'h01, addr=12'h005.
//     cycle+3: pixel_valid=1, pixel_data=bank0 word.
//  2. x=511,y=1023 (bounds off) -> sel=8'h80, addr=12'hFFF. Then y=64 -> sel=8'h02, addr=x.
//     y=71 -> same addr as y=64 (decimation).
//  3. Streaming x=0..7 with y=i*64 (a different bank each cycle) -> pixels return in order.
//     Each comes from the matching bank, 8 consecutive pixel_valid.
//  4. BOUNDS_EN: y=512 (bank 8) and x=600 -> rd_en=0, pixel_data=BG_PIXEL, oor_count=2.
//     Preload oor_count near max -> saturates at FFFF.
//  5. Three reads in flight, then flush -> no pixel_valid for those reads. Read issued the
//     cycle after flush returns normally.
//  6. Assert rst asynchronously mid-stream (between edges) -> all outputs 0 immediately.
//     RAM_LAT=3 rerun of test 3 passes with latency 5.

Source files
------------

// File: rtl/coord_ram_pkg.sv
// Shared types and helpers for the coordinate-to-banked-RAM read engine.
// Field widths here follow the default geometry (8 banks, 10-bit coordinates).
package coord_ram_pkg;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   // Bank index is never narrower than one bit, even for a single-bank build.
   function automatic int bank_idx_width(input int no_banks);
      return (clog2(no_banks) < 1) ? 1 : clog2(no_banks);
   endfunction

   localparam int NO_BANKS_DEF     = 8;
   localparam int COORDW_DEF       = 10;
   localparam int ROW_LOG2_DEF     = 3;
   localparam int Y_DECIM_LOG2_DEF = 3;

   localparam int BANKW     = COORDW_DEF - ROW_LOG2_DEF - Y_DECIM_LOG2_DEF;
   localparam int BANK_IDXW = bank_idx_width(NO_BANKS_DEF);
   localparam int TAG_FLAGW = 2;

   typedef struct packed {
      logic                 valid;
      logic                 oor;
      logic [BANK_IDXW-1:0] bank_idx;
   } tag_t;

   localparam int TAGW = $bits(tag_t);

endpackage

// File: rtl/coord_ram_tag_pipe.sv
// Delay line carrying {valid, oor, bank_idx} across the RAM read latency.
// Flush and reset both empty every stage so no stale read can surface.
module coord_ram_tag_pipe #(
   parameter int TAGW  = 5,
   parameter int DEPTH = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic [TAGW-1:0] tag_in,
   output logic [TAGW-1:0] tag_out
);

   logic [TAGW-1:0] stages [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stages[i] <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            stages[i] <= '0;
         end
      end else begin
         stages[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            stages[i] <= stages[i-1];
         end
      end
   end

   assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/coord_ram_reader.sv
// Display coordinate to banked-RAM read engine with in-order pixel return.
// Optional range checking and out-of-range counting: define COORD_RAM_BOUNDS_EN.
module coord_ram_reader
   import coord_ram_pkg::*;
#(
   parameter int NO_BANKS       = 8,
   parameter int COORDW         = 10,
   parameter int RAM_ADDR_WIDTH = 12,
   parameter int LINE_LOG2      = 9,
   parameter int ROW_LOG2       = 3,
   parameter int Y_DECIM_LOG2   = 3,
   parameter int DATAW          = 8,
   parameter int RAM_LAT        = 1,
   parameter logic [DATAW-1:0] BG_PIXEL = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         coord_valid,
   input  logic [COORDW-1:0]            x,
   input  logic [COORDW-1:0]            y,
   output logic                         rd_en,
   output logic [NO_BANKS-1:0]          rd_bank_select,
   output logic [RAM_ADDR_WIDTH-1:0]    rd_address,
   input  logic [NO_BANKS*DATAW-1:0]    bank_rdata,
   output logic                         pixel_valid,
   output logic [DATAW-1:0]             pixel_data,
   output logic [15:0]                  oor_count
);

   localparam int YSHIFT = ROW_LOG2 + Y_DECIM_LOG2;
   localparam int BW     = COORDW - YSHIFT;
   localparam int IDXW   = bank_idx_width(NO_BANKS);
   localparam int TW     = TAG_FLAGW + IDXW;

   typedef struct packed {
      logic            valid;
      logic            oor;
      logic [IDXW-1:0] bank_idx;
   } tag_s;

   logic [BW-1:0]             bank_field;
   logic [ROW_LOG2-1:0]       row_field;
   logic [LINE_LOG2-1:0]      x_field;
   logic [IDXW-1:0]           bank_idx;
   logic [RAM_ADDR_WIDTH-1:0] addr_next;
   logic [NO_BANKS-1:0]       sel_next;
   logic                      oor;
   logic                      issue;
   tag_s                      s1_tag;
   tag_s                      tag_q;
   logic [TW-1:0]             tag_pipe_out;
   logic [DATAW-1:0]          bank_word;

   // The address is a pure bit concatenation; the decimated y LSBs are simply dropped.
   assign bank_field = y[COORDW-1:YSHIFT];
   assign row_field  = y[YSHIFT-1:Y_DECIM_LOG2];
   assign x_field    = x[LINE_LOG2-1:0];
   assign bank_idx   = IDXW'(bank_field);
   assign addr_next  = RAM_ADDR_WIDTH'({row_field, x_field});

`ifdef COORD_RAM_BOUNDS_EN
   assign oor = (int'(bank_field) >= NO_BANKS) || (int'(x) >= (1 << LINE_LOG2));
`else
   logic unused_bits;
   assign oor         = 1'b0;
   assign unused_bits = ^{x, bank_field};
`endif

   assign issue = coord_valid && !oor;

   always_comb begin
      sel_next           = '0;
      sel_next[bank_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_en          <= 1'b0;
         rd_bank_select <= '0;
         rd_address     <= '0;
         s1_tag         <= '0;
      end else if (flush) begin
         rd_en          <= 1'b0;
         rd_bank_select <= '0;
         rd_address     <= '0;
         s1_tag         <= '0;
      end else begin
         rd_en          <= issue;
         rd_bank_select <= issue ? sel_next : '0;
         rd_address     <= issue ? addr_next : '0;
         s1_tag         <= coord_valid ? tag_s'{valid: 1'b1, oor: oor, bank_idx: bank_idx} : '0;
      end
   end

   coord_ram_tag_pipe #(
      .TAGW  (TW),
      .DEPTH (RAM_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .tag_in  (s1_tag),
      .tag_out (tag_pipe_out)
   );

   assign tag_q = tag_pipe_out;

   always_comb begin
      bank_word = '0;
      for (int b = 0; b < NO_BANKS; b++) begin
         if (int'(tag_q.bank_idx) == b) begin
            bank_word = bank_rdata[b*DATAW +: DATAW];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pixel_valid <= 1'b0;
         pixel_data  <= '0;
      end else if (flush) begin
         pixel_valid <= 1'b0;
         pixel_data  <= '0;
      end else begin
         pixel_valid <= tag_q.valid;
         if (!tag_q.valid) begin
            pixel_data <= '0;
         end else if (tag_q.oor) begin
            pixel_data <= BG_PIXEL;
         end else begin
            pixel_data <= bank_word;
         end
      end
   end

`ifdef COORD_RAM_BOUNDS_EN
   // Dropped (flush-cycle) coordinates are not counted; only reset clears the counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         oor_count <= '0;
      end else if (coord_valid && oor && !flush && (oor_count != 16'hFFFF)) begin
         oor_count <= oor_count + 16'd1;
      end
   end
`else
   assign oor_count = '0;
`endif

endmodule
